// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling, three-sample
// majority voting and a small output FIFO.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          asynchronous reset, active low (asserted when 0)
//   rx           serial input, idle high, asynchronous to clk
//   out_byte     FIFO head byte, meaningful while out_valid=1
//   out_valid    FIFO non-empty
//   out_ready    consumer accepts the head byte this cycle
//   is_receiving high while a frame is in progress (START/DATA/STOP)
//   recv_error   one-cycle pulse when a stop bit is sampled low
//   overrun      one-cycle pulse when a good byte is dropped (FIFO full)
//   fifo_count   number of bytes currently stored
//   dbg_state    current receiver FSM state, for observation only
//
// Output handshake: a byte transfers on every rising edge where
// out_valid=1 and out_ready=1. out_valid never depends on out_ready, and
// out_byte holds steady while out_valid=1 and out_ready=0.
module uart_rx_fifo #(
    parameter int CLKS_PER_TICK = 27,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          is_receiving,
    output logic                          recv_error,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    dbg_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [11:0]   TICK_LAST = 12'(CLKS_PER_TICK - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    // Synchronizer
    logic rx_meta_q, rx_meta_d;
    logic rxs_q, rxs_d;

    // Receiver
    state_t      state_q, state_d;
    logic [11:0] div_q, div_d;      // clocks within one oversample tick
    logic [3:0]  sub_q, sub_d;      // oversample ticks within one bit
    logic [2:0]  bit_q, bit_d;      // data bit index
    logic        s7_q, s7_d;
    logic        s8_q, s8_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        err_q, err_d;
    logic        ovr_q, ovr_d;
    logic        tick, mid, last, maj, push_req;

    // FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, full;

    assign rx_meta_d = rx;
    assign rxs_d     = rx_meta_q;

    // ---------------- receiver FSM, next state ----------------
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        sub_d    = sub_q;
        bit_d    = bit_q;
        s7_d     = s7_q;
        s8_d     = s8_q;
        shreg_d  = shreg_q;
        err_d    = 1'b0;
        push_req = 1'b0;

        tick = (div_q == TICK_LAST);
        mid  = tick && (sub_q == 4'd9);
        last = tick && (sub_q == 4'd15);
        // Third sample is the live value at tick 9.
        maj  = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);

        // The tick divider only runs while a frame is being sampled.
        if (state_q == S_IDLE || state_q == S_WAIT_HIGH) begin
            div_d = 12'd0;
        end else if (tick) begin
            div_d = 12'd0;
            sub_d = sub_q + 4'd1;
        end else begin
            div_d = div_q + 12'd1;
        end

        if (tick && sub_q == 4'd7) s7_d = rxs_q;
        if (tick && sub_q == 4'd8) s8_d = rxs_q;

        unique case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    div_d   = 12'd0;
                    sub_d   = 4'd0;
                    bit_d   = 3'd0;
                end
            end
            S_START: begin
                if (mid && maj) begin
                    state_d = S_IDLE;       // glitch shorter than half a bit
                end else if (last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (mid) shreg_d = {maj, shreg_q[7:1]};
                if (last) begin
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_STOP: begin
                // Leaving at tick 9 gives half a bit of margin for the
                // next start edge.
                if (mid) begin
                    if (maj) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        err_d    = 1'b1;
                        state_d  = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // A break holds the line low; wait it out so it yields a
                // single error rather than a stream of bogus frames.
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FIFO ----------------
    always_comb begin
        pop   = (count_q != '0) && out_ready;
        full  = (count_q == DEPTH_C);
        push  = push_req && (!full || pop);
        ovr_d = push_req && !push;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = shreg_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= S_IDLE;
            div_q     <= 12'd0;
            sub_q     <= 4'd0;
            bit_q     <= 3'd0;
            s7_q      <= 1'b0;
            s8_q      <= 1'b0;
            shreg_q   <= 8'd0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rxs_q     <= rxs_d;
            state_q   <= state_d;
            div_q     <= div_d;
            sub_q     <= sub_d;
            bit_q     <= bit_d;
            s7_q      <= s7_d;
            s8_q      <= s8_d;
            shreg_q   <= shreg_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign out_byte     = mem_q[rd_ptr_q];
    assign out_valid    = (count_q != '0);
    assign fifo_count   = count_q;
    assign recv_error   = err_q;
    assign overrun      = ovr_q;
    assign is_receiving = (state_q == S_START) || (state_q == S_DATA) ||
                          (state_q == S_STOP);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios followed by a randomized
// stream of frames, checked against a queue of expected bytes and counts
// of expected error/overrun events.
module tb_uart_rx_fifo;

    localparam int CPT   = 4;
    localparam int DEPTH = 4;
    localparam int BIT   = 16 * CPT;
    localparam int CW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic ready_fixed = 1'b0;
    logic ready_rand  = 1'b0;
    logic rand_en     = 1'b0;
    logic out_ready;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          is_receiving;
    logic          recv_error;
    logic          overrun;
    logic [CW-1:0] fifo_count;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    assign out_ready = rand_en ? ready_rand : ready_fixed;

    uart_rx_fifo #(
        .CLKS_PER_TICK (CPT),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .out_byte     (out_byte),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .is_receiving (is_receiving),
        .recv_error   (recv_error),
        .overrun      (overrun),
        .fifo_count   (fifo_count),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         err_pulses = 0;
    int         ovr_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    // Monitor: every accepted byte must be the oldest expected one; pulses
    // are counted in cycles so a stretched pulse shows up as an extra event.
    always @(negedge clk) begin
        if (rst) begin
            if (recv_error) err_pulses++;
            if (overrun)    ovr_pulses++;
            if (recv_error || overrun)
                check("err_ovr_exclusive", 32'(recv_error && overrun), 32'd0);
            if (out_valid && out_ready) begin
                check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("pop_data", 32'(out_byte), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        ready_rand = 1'($urandom_range(0, 1));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] d);
        rx = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            cyc(BIT);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits(d);
        rx = stop;
        cyc(BIT);
        rx = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         e0, o0, lat, n_badf;
        bit         seen;
        logic [7:0] d;
        logic [7:0] msg;

        // Reset values
        cyc(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_byte", 32'(out_byte), 32'h00);
        check("rst_is_receiving", 32'(is_receiving), 32'd0);
        check("rst_recv_error", 32'(recv_error), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        rst = 1'b1;
        cyc(4);

        // 1: single 0x55 with consumer ready, plus push latency window
        ready_fixed = 1'b1;
        e0 = err_pulses; o0 = ovr_pulses;
        exp_q.push_back(8'h55);
        send_bits(8'h55);
        rx = 1'b1;
        lat = 9 * BIT;
        seen = 1'b0;
        for (int k = 0; k < 2 * BIT && !seen; k++) begin
            cyc(1);
            lat++;
            if (out_valid) seen = 1'b1;
        end
        check("t1_valid_seen", 32'(seen), 32'd1);
        check("t1_head_byte", 32'(out_byte), 32'h55);
        check("t1_latency_window",
              32'(lat >= 9 * BIT + BIT / 2 && lat <= 9 * BIT + BIT / 2 + 4 + 2 * CPT), 32'd1);
        cyc(BIT);
        check("t1_drained", 32'(exp_q.size()), 32'd0);
        check("t1_out_valid_low", 32'(out_valid), 32'd0);
        check("t1_no_error", 32'(err_pulses - e0), 32'd0);
        check("t1_no_overrun", 32'(ovr_pulses - o0), 32'd0);

        // 2: back-to-back frames while stalled, then drain in order
        ready_fixed = 1'b0;
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        cyc(10);
        check("t2_fifo_count", 32'(fifo_count), 32'd3);
        check("t2_out_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("t2_head_stable", 32'(out_byte), 32'hA5);
            cyc(1);
        end
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hFF);
        ready_fixed = 1'b1;
        cyc(8);
        check("t2_drained", 32'(exp_q.size()), 32'd0);
        check("t2_fifo_empty", 32'(fifo_count), 32'd0);

        // 3: framing error followed by a break, then a clean frame
        e0 = err_pulses;
        send_bits(8'h81);
        rx = 1'b0;
        cyc(3 * BIT);
        rx = 1'b1;
        cyc(BIT);
        check("t3_one_error", 32'(err_pulses - e0), 32'd1);
        check("t3_fifo_empty", 32'(fifo_count), 32'd0);
        check("t3_idle", 32'(is_receiving), 32'd0);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        cyc(BIT);
        check("t3_next_frame", 32'(exp_q.size()), 32'd0);
        check("t3_still_one_error", 32'(err_pulses - e0), 32'd1);

        // 4: glitch of 6 ticks; also start-detect latency
        e0 = err_pulses;
        rx = 1'b0;
        cyc(2);
        check("t4_not_yet_receiving", 32'(is_receiving), 32'd0);
        cyc(1);
        check("t4_receiving", 32'(is_receiving), 32'd1);
        cyc(6 * CPT - 3);
        rx = 1'b1;
        cyc(BIT);
        check("t4_back_idle", 32'(is_receiving), 32'd0);
        check("t4_no_byte", 32'(fifo_count), 32'd0);
        check("t4_no_error", 32'(err_pulses - e0), 32'd0);

        // 5: overrun on the fifth frame with the consumer stalled
        ready_fixed = 1'b0;
        o0 = ovr_pulses;
        for (int v = 1; v <= 5; v++) begin
            send_frame(8'(v), 1'b1);
            if (v <= DEPTH) exp_q.push_back(8'(v));
        end
        cyc(4);
        check("t5_one_overrun", 32'(ovr_pulses - o0), 32'd1);
        check("t5_fifo_full", 32'(fifo_count), 32'(DEPTH));
        ready_fixed = 1'b1;
        cyc(10);
        check("t5_drained", 32'(exp_q.size()), 32'd0);
        check("t5_fifo_empty", 32'(fifo_count), 32'd0);

        // 6: reset in the middle of a frame with bytes queued
        ready_fixed = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        cyc(4);
        check("t6_queued", 32'(fifo_count), 32'd2);
        msg = 8'h7E;
        rx = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = msg[i];
            cyc(BIT);
        end
        rx = msg[4];
        cyc(BIT / 2);
        rst = 1'b0;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_out_byte", 32'(out_byte), 32'h00);
        check("t6_fifo_count", 32'(fifo_count), 32'd0);
        check("t6_is_receiving", 32'(is_receiving), 32'd0);
        check("t6_recv_error", 32'(recv_error), 32'd0);
        check("t6_overrun", 32'(overrun), 32'd0);
        rx = 1'b1;
        cyc(5);
        rst = 1'b1;
        cyc(BIT);
        ready_fixed = 1'b1;
        exp_q.push_back(8'h99);
        send_frame(8'h99, 1'b1);
        cyc(BIT);
        check("t6_after_reset", 32'(exp_q.size()), 32'd0);

        // 7: random byte stream, random consumer stalls, occasional bad stop
        rand_en = 1'b1;
        e0 = err_pulses; o0 = ovr_pulses;
        n_badf = 0;
        for (int f = 0; f < 48; f++) begin
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                n_badf++;
                send_frame(d, 1'b0);
                cyc(BIT + $urandom_range(0, 20));
            end else begin
                exp_q.push_back(d);
                send_frame(d, 1'b1);
                cyc($urandom_range(0, 20));
            end
        end
        rand_en = 1'b0;
        ready_fixed = 1'b1;
        cyc(BIT);
        check("t7_all_received", 32'(exp_q.size()), 32'd0);
        check("t7_error_count", 32'(err_pulses - e0), 32'(n_badf));
        check("t7_no_overrun", 32'(ovr_pulses - o0), 32'd0);
        check("t7_fifo_empty", 32'(fifo_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Standalone UART receiver with 16x oversampling, three-sample majority voting and a small output FIFO. It is the receiving end for the `uart` transmit path. It deserialises 8N1 frames from an asynchronous `rx` line and presents bytes to the core over a valid/ready handshake. It sits beside `uart` in the I/O subsystem and is verified in loopback against a `uart` instance's `tx` output.

## Interface
- CLKS_PER_TICK, 27, clk cycles per oversample tick; bit time = 16*CLKS_PER_TICK cycles; legal range 2..4095
- FIFO_DEPTH, 4, output FIFO entries; power of two, 2..16
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- rx  in  1  serial input, idle high, asynchronous to clk
- out_byte  out  8  FIFO head byte, valid when out_valid=1
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head byte this cycle
- is_receiving  out  1  high from start-bit detection until the frame ends (stop sampled or glitch rejected)
- recv_error  out  1  one-cycle pulse on framing error (stop bit sampled 0)
- overrun  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of stored bytes

## Operation
- rx passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized value `rxs`.
- Tick generator: counter 0..CLKS_PER_TICK-1, emits a 1-cycle tick on wrap. It is held at 0 in IDLE and restarts at 0 on start detection.
- Per-bit tick counter 0..15. Samples are taken at ticks 7, 8 and 9; the bit value is the majority of the three.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rxs=0, go to START and clear the counters.
  - START: at tick 9, if the majority is 1 (glitch), return to IDLE with no error. Otherwise go to DATA at tick 15.
  - DATA: shift bits LSB first into an 8-bit register. After bit 7's tick 15, go to STOP.
  - STOP: at tick 9 evaluate the majority.
    - If 1: push the byte to the FIFO, or pulse overrun if the push is not possible. Go to IDLE.
    - If 0: pulse recv_error, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. This handles break conditions, which produce exactly one error.
- A new start bit may be detected the cycle after returning to IDLE. This permits back-to-back frames with a half-bit stop margin.
- FIFO: circular buffer with wr/rd pointers of $clog2(FIFO_DEPTH) bits that wrap naturally, plus a separate count.
  - Pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Push while full is allowed only if a pop happens in the same cycle. Otherwise the byte is dropped and overrun pulses.
  - out_ready while empty has no effect.
- out_byte is the registered/array-read head entry. Its value is don't-care when out_valid=0, but it must not change while out_valid=1 and out_ready=0.

## Timing
- Reset values:
  - out_valid=0, out_byte=0x00, is_receiving=0, recv_error=0, overrun=0, fifo_count=0.
  - FSM in IDLE, synchronizer=1, all counters 0.
- Start detection latency: 2 cycles of synchronizer plus 1 cycle of FSM after the rx falling edge.
- Byte push occurs on the cycle of the stop-bit tick 9. out_valid rises and out_byte is valid on the next cycle.
- Total from start-edge to out_valid: about 9.5 bit times + 4 cycles.
- recv_error and overrun are high for exactly one clk cycle per event. They are never asserted together for the same frame.
- is_receiving rises the cycle after IDLE exits. It falls on the cycle the FSM leaves STOP, or leaves START on a glitch.
- Reset asserted mid-frame or mid-FIFO: everything returns to its reset values immediately. No partial byte is pushed and FIFO contents are lost.
- Consumer may hold out_ready=1 continuously. Throughput is then limited only by the line rate.

## Test plan
- CLKS_PER_TICK=4, send 0x55 8N1 on rx, out_ready=1 → out_valid pulses once with out_byte=0x55; recv_error=0, overrun=0.
- Back-to-back 0xA5, 0x3C, 0xFF with out_ready=0, then drain → fifo_count reaches 3; pops return 0xA5, 0x3C, 0xFF in order; out_byte is stable while stalled.
- Frame 0x81 with stop bit forced 0, rx held low for 2 further bit times → exactly one recv_error pulse; FIFO stays empty; the next frame 0x42 is received correctly.
- rx low for 6 ticks (less than half a bit), then high → no byte, no error; is_receiving pulses and returns to 0.
- FIFO_DEPTH=4, out_ready=0, send 0x01..0x05 → one overrun pulse on the 5th frame; drain yields 0x01..0x04.
- Reset asserted during bit 4 of 0x7E with 2 bytes queued → all outputs at reset values; after release, 0x99 is received cleanly.
- Loopback with the `uart` transmitter (same clock, matching divisor), 256 sequential bytes → all received in order with zero errors.
